// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_pkg
// Desc     : Shared types and LC-3 device-register constants for the responder.
// Revision : 1.0
// ============================================================================
package lc3_mem_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] DSR_READY = 16'h8000;

  function automatic logic is_dev_reg(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
           (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder_if
// Desc     : CPU <-> memory handshake bundle (request, data, ready).
// Revision : 1.0
// ============================================================================
interface lc3_mem_responder_if;

  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_array
// Desc     : Single-port synchronous word RAM, registered read, no reset.
// Revision : 1.0
// ============================================================================
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int MEM_WORDS = 65536,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [AW-1:0]     addr,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder
// Desc     : LC-3 memory responder with programmable wait states; device
//            registers decoded when LC3_MEM_MMIO_EN is defined.
// Revision : 1.0
// ============================================================================
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int MEM_WORDS   = 65536,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  lc3_mem_responder_if.slave    bus,
  output logic                  busy,
  output logic                  proto_err,
  output logic                  disp_valid,
  output logic [7:0]            disp_data
);

  localparam int         AW          = $clog2(MEM_WORDS);
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  mem_state_t r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_is_wr;
  logic        r_ready;
  logic        r_arr_rd;
  logic [15:0] r_rdata;
  logic        r_proto_err;

  logic        w_req;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_drop;
  logic        w_cur_wr;
  logic [15:0] w_cur_addr;
  logic [15:0] w_cur_wdata;
  logic        w_cur_mmio;
  logic [15:0] w_mmio_rdata;
  logic        w_arr_we;
  logic [15:0] w_arr_rdata;

  assign w_req    = bus.mem_re | bus.mem_we;
  assign w_accept = (r_state == ST_IDLE) && w_req;

  // In IDLE the live bus is used so a zero-wait access can finish on its accept edge.
  assign w_cur_wr    = (r_state == ST_IDLE) ? bus.mem_we    : r_is_wr;
  assign w_cur_addr  = (r_state == ST_IDLE) ? bus.mem_addr  : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? bus.mem_wdata : r_wdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_enter_resp   = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_wait_cnt_nxt = c_wait_load;
          if (c_wait_load == 4'd0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
          w_drop      = 1'b1;
        end else if (r_wait_cnt == 4'd1) begin
          w_state_nxt    = ST_RESP;
          w_enter_resp   = 1'b1;
          w_wait_cnt_nxt = 4'd0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef LC3_MEM_MMIO_EN
  logic       r_disp_valid;
  logic [7:0] r_disp_data;

  assign w_cur_mmio   = is_dev_reg(w_cur_addr);
  assign w_mmio_rdata = (w_cur_addr == DSR_ADDR) ? DSR_READY : 16'h0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else begin
      r_disp_valid <= w_enter_resp && w_cur_wr && (w_cur_addr == DDR_ADDR);
      if (w_enter_resp && w_cur_wr && (w_cur_addr == DDR_ADDR)) begin
        r_disp_data <= w_cur_wdata[7:0];
      end
    end
  end

  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;
`else
  assign w_cur_mmio   = 1'b0;
  assign w_mmio_rdata = 16'h0000;
  assign disp_valid   = 1'b0;
  assign disp_data    = 8'h00;
`endif

  // Gated by reset_n so a held request cannot commit while reset is asserted.
  assign w_arr_we = w_enter_resp & w_cur_wr & ~w_cur_mmio & reset_n;

  lc3_mem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .addr  (w_cur_addr[AW-1:0]),
    .wdata (w_cur_wdata),
    .rdata (w_arr_rdata)
  );

  generate
    if (AW < 16) begin : g_addr_sink
      logic w_unused_hi;
      assign w_unused_hi = ^w_cur_addr[15:AW];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_is_wr     <= 1'b0;
      r_ready     <= 1'b0;
      r_arr_rd    <= 1'b0;
      r_rdata     <= 16'h0000;
      r_proto_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_is_wr <= bus.mem_we;
      end
      if ((w_accept && bus.mem_re && bus.mem_we) || w_drop) begin
        r_proto_err <= 1'b1;
      end
      r_ready  <= w_enter_resp;
      r_arr_rd <= w_enter_resp & ~w_cur_wr & ~w_cur_mmio;
      // Array reads surface straight from the RAM output register during RESP and are held afterwards.
      if (w_enter_resp && !w_cur_wr && w_cur_mmio) begin
        r_rdata <= w_mmio_rdata;
      end else if (r_arr_rd) begin
        r_rdata <= w_arr_rdata;
      end
    end
  end

  assign bus.mem_rdata = r_arr_rd ? w_arr_rdata : r_rdata;
  assign bus.mem_ready = r_ready;
  assign busy          = (r_state != ST_IDLE);
  assign proto_err     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_responder
// Desc     : Randomized scoreboard bench for lc3_mem_responder.
// Revision : 1.0
// ============================================================================
module tb_lc3_mem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int W         = 2;

  typedef struct {
    logic [15:0] rdata;
    logic        proto;
    logic        dv;
    logic [7:0]  dd;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy, proto_err, disp_valid;
  logic [7:0] disp_data;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  exp_t        q[$];
  logic [15:0] model[int];
  logic [15:0] exp_last  = 16'h0000;
  logic        exp_proto = 1'b0;
  logic [7:0]  exp_dd    = 8'h00;
  logic [15:0] pool [8] = '{16'h0010, 16'h1010, 16'h2020, 16'h0020,
                            16'h0FFF, 16'h1FFF, 16'h0E06, 16'h0123};

  lc3_mem_responder_if bus();

  lc3_mem_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_CYCLES (W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .proto_err  (proto_err),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic bit tb_mmio(input logic [15:0] a);
`ifdef LC3_MEM_MMIO_EN
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge of the cycle where mem_ready was seen.
  task automatic access(input bit rd, input bit both, input logic [15:0] a,
                        input logic [15:0] d, input bit b2b);
    exp_t e;
    bit   wr, got;
    int   idx;
    idx = int'(a) % MEM_WORDS;
    wr  = !rd || both;
    e.dv = 1'b0;
    if (both) exp_proto = 1'b1;
    if (wr) begin
      if (!tb_mmio(a)) model[idx] = d;
      else if (a == 16'hFE06) begin
        e.dv   = 1'b1;
        exp_dd = d[7:0];
      end
    end else begin
      if (tb_mmio(a)) exp_last = (a == 16'hFE04) ? 16'h8000 : 16'h0000;
      else if (model.exists(idx)) exp_last = model[idx];
      else $display("note: read of unwritten index %0h", idx);
    end
    e.rdata = exp_last;
    e.proto = exp_proto;
    e.dd    = exp_dd;
    e.acc   = cyc + (b2b ? 2 : 1);
    q.push_back(e);
    bus.mem_re    = rd || both;
    bus.mem_we    = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    if (!got && q.size() > 0) q.delete(q.size() - 1);
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n !== 1'b1) continue;
      if (bus.mem_ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 32'(bus.mem_ready), 32'd0);
        end else begin
          e = q.pop_front();
          check("latency", 32'(cyc - e.acc), 32'(W));
          check("rdata", 32'(bus.mem_rdata), 32'(e.rdata));
          check("proto_err", 32'(proto_err), 32'(e.proto));
          check("busy_in_resp", 32'(busy), 32'd1);
          check("disp_valid", 32'(disp_valid), 32'(e.dv));
          check("disp_data", 32'(disp_data), 32'(e.dd));
        end
      end else begin
        check("stray_disp", 32'(disp_valid), 32'd0);
      end
    end
  end

  initial begin
    int          gap;
    bit          rd, both;
    logic [15:0] a;
    reset_n       = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_rdata", 32'(bus.mem_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write/read, back-to-back
    access(0, 0, 16'h3000, 16'h1234, 0);
    access(1, 0, 16'h3000, 16'h0000, 1);

    // Simultaneous re/we: treated as write, sticky error
    access(0, 1, 16'h3001, 16'hBEEF, 1);
    access(1, 0, 16'h3001, 16'h0000, 1);
    access(0, 0, 16'h3003, 16'h1111, 1);

    // Request dropped during WAIT
    @(negedge clk);
    bus.mem_re   = 1'b1;
    bus.mem_addr = 16'h3002;
    @(negedge clk);
    check("drop_busy_wait", 32'(busy), 32'd1);
    @(negedge clk);
    bus.mem_re = 1'b0;
    @(negedge clk);
    exp_proto = 1'b1;
    check("drop_busy_idle", 32'(busy), 32'd0);
    check("drop_proto", 32'(proto_err), 32'd1);
    check("drop_rdata_held", 32'(bus.mem_rdata), 32'(exp_last));
    repeat (2) @(negedge clk);

    // Reset during the WAIT of a write
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 16'h3003;
    bus.mem_wdata = 16'h5555;
    @(negedge clk);
    reset_n    = 1'b0;
    bus.mem_we = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.mem_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_proto", 32'(proto_err), 32'd0);
    check("midrst_rdata", 32'(bus.mem_rdata), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    exp_proto = 1'b0;
    exp_last  = 16'h0000;
    @(negedge clk);
    access(1, 0, 16'h3003, 16'h0000, 0);

    // Address wrap modulo MEM_WORDS
    access(0, 0, 16'h1005, 16'hAAAA, 1);
    access(1, 0, 16'h0005, 16'h0000, 1);

    // Seed the random pool, then randomized traffic
    for (int i = 0; i < 8; i++) access(0, 0, pool[i], 16'($urandom), 1);
    for (int n = 0; n < 60; n++) begin
      gap  = $urandom_range(0, 2);
      a    = pool[$urandom_range(0, 7)];
      rd   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      repeat (gap) @(negedge clk);
      access(rd, both, a, 16'($urandom), gap == 0);
    end

`ifdef LC3_MEM_MMIO_EN
    @(negedge clk);
    access(1, 0, 16'hFE04, 16'h0000, 0);
    access(1, 0, 16'hFE00, 16'h0000, 1);
    access(0, 0, 16'hFE06, 16'h0041, 1);
    access(1, 0, 16'h0E06, 16'h0000, 1);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
